// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD arithmetic blocks.
//   BCD_DIGIT_W  : bits per BCD digit
//   BCD_MAX      : largest legal digit value
//   bcd_state_t  : controller states of the serial adder
//   is_bcd_digit : 1 when a 4-bit nibble holds a legal decimal digit
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bcd_state_t;

    function automatic logic is_bcd_digit(input logic [BCD_DIGIT_W-1:0] d);
        return (d <= BCD_DIGIT_W'(BCD_MAX));
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD add / nine's-complement-add cell (purely combinational).
//   a   : operand A digit
//   b   : operand B digit
//   sub : 1 = replace b by its nine's complement (9 - b) before adding
//   ci  : decimal carry in
//   s   : result digit
//   co  : decimal carry out
// Digits above 9 are not trapped here; they flow through the same rule.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   sub,
    input  logic                   ci,
    output logic [BCD_DIGIT_W-1:0] s,
    output logic                   co
);

    logic [BCD_DIGIT_W-1:0] b_eff;
    logic [BCD_DIGIT_W:0]   t;
    logic [BCD_DIGIT_W:0]   t_adj;

    always_comb begin
        // Nine's complement wraps modulo 16 for illegal b digits.
        b_eff = sub ? (BCD_DIGIT_W'(BCD_MAX) - b) : b;
        t     = {1'b0, a} + {1'b0, b_eff} + {{BCD_DIGIT_W{1'b0}}, ci};
        t_adj = t - 5'd10;
        if (t > 5'(BCD_MAX)) begin
            s  = t_adj[BCD_DIGIT_W-1:0];
            co = 1'b1;
        end else begin
            s  = t[BCD_DIGIT_W-1:0];
            co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor, least-significant digit first.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : request, sampled only while idle
//   sub   : 0 = a + b, 1 = a - b (ten's complement), latched with start
//   cin   : carry-in (add) / borrow-in (sub), latched with start
//   a, b  : packed BCD operands, digit 0 in [3:0]
//   busy  : operation in progress (RUN and DONE)
//   done  : one-cycle pulse, result valid
//   sum   : packed BCD result, held until the next accepted start
//   cout  : final decimal carry (sub: 1 = no borrow)
//   err   : some digit of the latched operands was above 9
// Timing: start accepted at edge k, digits written at edges k+1..k+DIGITS,
// done high in the cycle after edge k+DIGITS+1.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          sub,
    input  logic                          cin,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
    output logic                          cout,
    output logic                          err
);

    localparam int W = BCD_DIGIT_W * DIGITS;

    bcd_state_t             state_reg;
    logic [CNT_W-1:0]       index_reg;
    logic [W-1:0]           a_reg;
    logic [W-1:0]           b_reg;
    logic                   sub_reg;
    logic                   carry_reg;
    logic [W-1:0]           sum_reg;
    logic                   cout_reg;
    logic                   err_reg;
    logic                   done_reg;

    logic [BCD_DIGIT_W-1:0] digit_s;
    logic                   digit_co;
    logic [DIGITS-1:0]      bad_digit;
    logic                   any_bad;

    // Validity of every input digit, evaluated only when start is accepted.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_check
        assign bad_digit[gi] = !is_bcd_digit(a[gi*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
                               !is_bcd_digit(b[gi*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
    assign any_bad = |bad_digit;

    // Operands are shifted right each RUN cycle, so the current digit is
    // always in the low nibble.
    bcd_digit_add u_digit (
        .a   (a_reg[BCD_DIGIT_W-1:0]),
        .b   (b_reg[BCD_DIGIT_W-1:0]),
        .sub (sub_reg),
        .ci  (carry_reg),
        .s   (digit_s),
        .co  (digit_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            index_reg <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        sub_reg   <= sub;
                        // Subtraction is A + (10^n - 1 - B) + 1, so a zero
                        // borrow-in becomes an initial carry of one.
                        carry_reg <= sub ? ~cin : cin;
                        index_reg <= '0;
                        sum_reg   <= '0;
                        err_reg   <= any_bad;
                        state_reg <= RUN;
                    end
                end

                RUN: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (index_reg == CNT_W'(i)) begin
                            sum_reg[i*BCD_DIGIT_W +: BCD_DIGIT_W] <= digit_s;
                        end
                    end
                    carry_reg <= digit_co;
                    a_reg     <= a_reg >> BCD_DIGIT_W;
                    b_reg     <= b_reg >> BCD_DIGIT_W;
                    if (index_reg == CNT_W'(DIGITS - 1)) begin
                        state_reg <= DONE;
                    end else begin
                        index_reg <= index_reg + 1'b1;
                    end
                end

                DONE: begin
                    // Two cycles here: the first registers the result flags,
                    // the second is the visible done pulse. busy stays high.
                    if (!done_reg) begin
                        done_reg <= 1'b1;
                        cout_reg <= carry_reg;
                    end else begin
                        done_reg  <= 1'b0;
                        index_reg <= '0;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    // Stimulus only: present one request for exactly one rising edge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sv, input logic cv);
        @(negedge clk);
        a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    endtask

    // Stimulus only: count falling edges until done, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, sum, cout, err} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b err=%b, required all 0",
                     busy, done, sum, cout, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: busy=%b done=%b sum=%h", busy, done, sum);
    endtask

    task automatic test_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic sv, input logic cv, input logic [W-1:0] exp_sum,
                           input logic exp_cout, input logic exp_err);
        int cyc;
        issue(av, bv, sv, cv);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy: got %b, required 1", name, busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL %s latency: done after %0d cycles past accept edge, required 5", name, cyc);
        end
        checks++;
        if ({sum, cout, err, busy} !== {exp_sum, exp_cout, exp_err, 1'b1}) begin
            errors++;
            $display("FAIL %s result: sum=%h cout=%b err=%b busy=%b, required sum=%h cout=%b err=%b busy=1",
                     name, sum, cout, err, busy, exp_sum, exp_cout, exp_err);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, sum, cout, err} !== {1'b0, 1'b0, exp_sum, exp_cout, exp_err}) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b sum=%h cout=%b err=%b, required done=0 busy=0 held",
                     name, done, busy, sum, cout, err);
        end
        $display("%s: a=%h b=%h sub=%b cin=%b -> sum=%h cout=%b err=%b (%0d cycles)",
                 name, av, bv, sv, cv, sum, cout, err, cyc + 1);
    endtask

    task automatic test_err_hold();
        test_op("err_op", 16'h00A0, 16'h0001, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_hold: err=%b, required 1", err);
        end
        test_op("err_clear", 16'h0012, 16'h0034, 1'b0, 1'b0, 16'h0046, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        issue(16'h1234, 16'h8766, 1'b0, 1'b0);
        // issue() returns in RUN cycle 1; pulse a conflicting start here and in cycle 3
        for (int c = 1; c <= 10; c++) begin
            if (c == 1 || c == 3) begin
                a = 16'h5555; b = 16'h4444; sub = 1'b1; cin = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                checks++;
                if ({sum, cout} !== {16'h0000, 1'b1}) begin
                    errors++;
                    $display("FAIL ignore_start result: sum=%h cout=%b, required 0000/1", sum, cout);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignore_start pulses: got %0d, required 1", pulses);
        end
        $display("ignore_start: done pulses=%0d sum=%h cout=%b", pulses, sum, cout);
    endtask

    task automatic test_reset_mid_run();
        int pulses = 0;
        issue(16'h1234, 16'h8766, 1'b0, 1'b0);
        @(negedge clk);            // RUN cycle 2
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, cout} !== {1'b0, 1'b0, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b, required 0/0/0000/0",
                     busy, done, sum, cout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid no_done: activity seen in %0d cycles, required 0", pulses);
        end
        $display("reset_mid: busy=%b sum=%h after release", busy, sum);
        test_op("after_reset", 16'h5000, 16'h0001, 1'b1, 1'b0, 16'h4999, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_op("add_wrap", 16'h1234, 16'h8766, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        test_op("sub_borrowfree", 16'h5000, 16'h0001, 1'b1, 1'b0, 16'h4999, 1'b1, 1'b0);
        test_op("sub_negative", 16'h0001, 16'h0002, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b0);
        test_op("add_ripple", 16'h0999, 16'h0001, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0);
        test_op("sub_borrowin", 16'h0100, 16'h0050, 1'b1, 1'b1, 16'h0049, 1'b1, 1'b0);
        test_err_hold();
        test_ignore_start();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Multi-digit packed-BCD adder/subtractor; processes one decimal digit per clock, least-significant digit first.
- Generalises the single-digit combinational BCD add to DIGITS digits.
- Adds a subtract mode (ten's complement), a start/busy/done handshake, carry/borrow out and an invalid-digit error flag.
- Sits between operand registers and the display/result path of the calculator datapath.

Parameters:
- DIGITS, 4: number of BCD digits per operand (>=1); operand width is 4*DIGITS.
- CNT_W, $clog2(DIGITS+1): width of the digit index counter (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request; sampled only when busy=0.
- sub  in  1  0 = A+B, 1 = A-B; latched with start.
- cin  in  1  carry-in (add) / borrow-in (sub); latched with start.
- a  in  4*DIGITS  operand A, packed BCD, digit 0 in [3:0].
- b  in  4*DIGITS  operand B, packed BCD.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: result valid.
- sum  out  4*DIGITS  packed BCD result, held until next accepted start.
- cout  out  1  final decimal carry (sub: 1 = no borrow, A>=B+cin).
- err  out  1  any digit of latched A or B > 9; held with sum.

Behaviour:
- Reset (rst_n=0, any time, including mid-operation): state IDLE, busy=0, done=0, sum=0, cout=0, err=0, index=0, internal operand and carry registers 0. Any operation in flight is discarded.
- States:
  - IDLE: start=1 -> latch a, b, sub, cin; carry <= sub ? ~cin : cin; index <= 0; sum <= 0; err <= (any digit of a or b > 9); go to RUN.
  - RUN: each cycle process digit[index], shift into sum[index]; index==DIGITS-1 -> DONE, else index+1.
  - DONE: done=1 for exactly this cycle, cout <= final carry; next cycle IDLE. start in DONE is ignored.
- Per-digit arithmetic:
  - b' = sub ? (4'd9 - b_digit) mod 16 : b_digit.
  - t[4:0] = a_digit + b' + carry.
  - t>9: digit = (t-10)[3:0], carry=1; else digit = t[3:0], carry=0.
- Latency: start sampled at edge k; digits written at edges k+1..k+DIGITS; done high during the cycle after edge k+DIGITS+1; DIGITS+2 cycles start-to-done.
- busy=1 in RUN and DONE.
- start while busy is ignored; no queueing.
- Outputs sum/cout/err keep the last result through IDLE. sum is partially updated during RUN and is valid only when done=1 or after it.
- Sub result with cout=0 is the ten's complement (e.g. 0001-0002 = 9999).
- Invalid digits (>9): computation proceeds using the rule above unchanged; result unspecified, err=1.
- Operand inputs are don't-care except in the start-accept cycle.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_W=4, BCD_MAX=9.
  - State enum {IDLE, RUN, DONE}.
  - Function is_bcd_digit.
- Sub-module bcd_digit_add (combinational): a, b, sub, ci -> s, co. It is the one-digit add/complement cell, reusable by future parallel adders.

Test Plan:
- DIGITS=4, add, a=0x1234, b=0x8766, cin=0 -> after 6 cycles done=1, sum=0x0000, cout=1, err=0.
- Sub, a=0x5000, b=0x0001, cin=0 -> sum=0x4999, cout=1. Sub, a=0x0001, b=0x0002 -> sum=0x9999, cout=0.
- Add, a=0x0999, b=0x0001, cin=1 -> sum=0x1001, cout=0 (ripple through three digits).
- a=0x00A0, b=0x0001, add -> err=1 held until next start; then a valid op clears err=0.
- Start pulsed again in RUN cycles 1 and 3 with different operands -> ignored; the first result is unchanged; exactly one done pulse.
- rst_n low mid-RUN (cycle 2) -> immediately busy=0, sum=0, cout=0, no done; a fresh start after release gives a correct result.
